// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, in front of the BRAM controller.
// Master 0 is the CPU and master 1 is the loader/debug port. The loader can lock out master 0.
// The path returns to idle after every transaction, so s_mem_valid is low for at least one
// cycle between transactions.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_mem_valid,
    input  logic [ADDR_W-1:0] m0_mem_addr,
    input  logic [DATA_W-1:0] m0_mem_wdata,
    input  logic [3:0]        m0_mem_wstrb,
    output logic              m0_mem_ready,
    output logic [DATA_W-1:0] m0_mem_rdata,

    input  logic              m1_mem_valid,
    input  logic [ADDR_W-1:0] m1_mem_addr,
    input  logic [DATA_W-1:0] m1_mem_wdata,
    input  logic [3:0]        m1_mem_wstrb,
    output logic              m1_mem_ready,
    output logic [DATA_W-1:0] m1_mem_rdata,

    input  logic              m1_lock,

    output logic              s_mem_valid,
    output logic [ADDR_W-1:0] s_mem_addr,
    output logic [DATA_W-1:0] s_mem_wdata,
    output logic [3:0]        s_mem_wstrb,
    input  logic              s_mem_ready,
    input  logic [DATA_W-1:0] s_mem_rdata,

    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;  // 0: master 0 served last, 1: master 1
    logic   req0, req1;

    // While the loader holds the lock, master 0 requests are not visible to arbitration.
    assign req0 = m0_mem_valid & ~m1_lock;
    assign req1 = m1_mem_valid;

    // Read data is broadcast; only the ready pulse tells a master that the data is its own.
    assign m0_mem_rdata = s_mem_rdata;
    assign m1_mem_rdata = s_mem_rdata;

    // Next state: pick a master in idle (a tie goes to the one not served last), release on ready.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_grant_q ? StGrant0 : StGrant1;
                end else if (req0) begin
                    state_d = StGrant0;
                end else if (req1) begin
                    state_d = StGrant1;
                end
            end
            StGrant0: begin
                if (s_mem_ready) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b0;
                end
            end
            StGrant1: begin
                if (s_mem_ready) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register. Reset makes master 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Bus mux. The grant is held until ready even if the master drops valid early.
    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = 4'b0000;
        m0_mem_ready = 1'b0;
        m1_mem_ready = 1'b0;
        grant_o      = 2'b00;
        unique case (state_q)
            StGrant0: begin
                s_mem_valid  = m0_mem_valid;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = s_mem_ready;
                grant_o      = 2'b01;
            end
            StGrant1: begin
                s_mem_valid  = m1_mem_valid;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = s_mem_ready;
                grant_o      = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed cycle table for the reset, round-robin, lock and reset
// corner cases, then random traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_mem_valid, m1_mem_valid;
    logic [31:0] m0_mem_addr, m1_mem_addr, m0_mem_wdata, m1_mem_wdata;
    logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
    logic        m0_mem_ready, m1_mem_ready;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic        m1_lock;
    logic        s_mem_valid;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_mem_ready;
    logic [31:0] s_mem_rdata;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_mem_valid (m0_mem_valid),
        .m0_mem_addr  (m0_mem_addr),
        .m0_mem_wdata (m0_mem_wdata),
        .m0_mem_wstrb (m0_mem_wstrb),
        .m0_mem_ready (m0_mem_ready),
        .m0_mem_rdata (m0_mem_rdata),
        .m1_mem_valid (m1_mem_valid),
        .m1_mem_addr  (m1_mem_addr),
        .m1_mem_wdata (m1_mem_wdata),
        .m1_mem_wstrb (m1_mem_wstrb),
        .m1_mem_ready (m1_mem_ready),
        .m1_mem_rdata (m1_mem_rdata),
        .m1_lock      (m1_lock),
        .s_mem_valid  (s_mem_valid),
        .s_mem_addr   (s_mem_addr),
        .s_mem_wdata  (s_mem_wdata),
        .s_mem_wstrb  (s_mem_wstrb),
        .s_mem_ready  (s_mem_ready),
        .s_mem_rdata  (s_mem_rdata),
        .grant_o      (grant_o)
    );

    // Reference model: who owns the bus (-1 nobody) and who was served last.
    int owner    = -1;
    int last_srv = 1;

    task automatic model_edge();
        bit w0, w1;
        w0 = m0_mem_valid && !m1_lock;
        w1 = m1_mem_valid;
        if (!reset_n) begin
            owner    = -1;
            last_srv = 1;
        end else if (owner < 0) begin
            if (w0 && w1)  owner = 1 - last_srv;
            else if (w0)   owner = 0;
            else if (w1)   owner = 1;
        end else if (s_mem_ready) begin
            last_srv = owner;
            owner    = -1;
        end
    endtask

    function automatic logic [159:0] model_out();
        logic sv, rd0, rd1;
        logic [31:0] a, d;
        logic [3:0] st;
        logic [1:0] g;
        sv = 1'b0; rd0 = 1'b0; rd1 = 1'b0; a = '0; d = '0; st = '0; g = 2'b00;
        if (owner == 0) begin
            sv = m0_mem_valid; a = m0_mem_addr; d = m0_mem_wdata; st = m0_mem_wstrb;
            rd0 = s_mem_ready; g = 2'b01;
        end else if (owner == 1) begin
            sv = m1_mem_valid; a = m1_mem_addr; d = m1_mem_wdata; st = m1_mem_wstrb;
            rd1 = s_mem_ready; g = 2'b10;
        end
        return {23'd0, sv, a, d, st, rd0, rd1, g, s_mem_rdata, s_mem_rdata};
    endfunction

    function automatic logic [159:0] dut_out();
        return {23'd0, s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb, m0_mem_ready,
                m1_mem_ready, grant_o, m0_mem_rdata, m1_mem_rdata};
    endfunction

    task automatic check(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Directed cycle table: inputs for one cycle and the outputs expected in that cycle.
    typedef struct packed {
        logic       rst_n, v0, v1, lk, sr;
        logic       e_sv, e_rd0, e_rd1;
        logic [1:0] e_g;
    } vec_t;

    function automatic vec_t mk(logic r, logic v0, logic v1, logic lk, logic sr,
                                logic sv, logic rd0, logic rd1, logic [1:0] g);
        vec_t v;
        v.rst_n = r; v.v0 = v0; v.v1 = v1; v.lk = lk; v.sr = sr;
        v.e_sv = sv; v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_g = g;
        return v;
    endfunction

    // Cycle end: the model follows the same edge the DUT sees, then inputs move 1 time unit later.
    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [67:0] exp_pl;

        // Reset held with master 0 requesting.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        // Single master 0 read with two wait cycles, then the mandatory gap.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 2'b01));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 2'b01));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'b01));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        // Reset taken while in a master 0 grant.
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 2'b01));
        // Both requesting from reset: 0,1,0,1.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 2'b01));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1, 2'b10));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 2'b01));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 2'b10));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1, 2'b10));
        // Lock: four master 1 transactions although both request.
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 2'b00));
            vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 1, 2'b10));
        end
        // Lock dropped: master 0 next.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 2'b01));
        // Lock raised mid master 0 grant: transaction completes, then master 1.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 2'b01));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 2'b01));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 2'b10));
        // Reset during master 1 grant; a stale slave ready afterwards is ignored.
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 2'b10));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 2'b01));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 2'b01));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00));

        // Fixed payloads during the directed part.
        m0_mem_addr  = 32'h0000_0010; m0_mem_wdata = 32'hA5A5_A5A5; m0_mem_wstrb = 4'b0000;
        m1_mem_addr  = 32'h0000_0020; m1_mem_wdata = 32'h1234_5678; m1_mem_wstrb = 4'b1111;
        s_mem_rdata  = 32'hDEAD_BEEF;
        reset_n = 1'b0; m0_mem_valid = 1'b1; m1_mem_valid = 1'b0; m1_lock = 1'b0;
        s_mem_ready = 1'b0;
        finish_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n      = vecs[i].rst_n;
            m0_mem_valid = vecs[i].v0;
            m1_mem_valid = vecs[i].v1;
            m1_lock      = vecs[i].lk;
            s_mem_ready  = vecs[i].sr;
            @(negedge clk);
            check($sformatf("row%0d_ctl", i),
                  {155'd0, s_mem_valid, m0_mem_ready, m1_mem_ready, grant_o},
                  {155'd0, vecs[i].e_sv, vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_g});
            if (vecs[i].e_g == 2'b01)      exp_pl = {32'h0000_0010, 32'hA5A5_A5A5, 4'b0000};
            else if (vecs[i].e_g == 2'b10) exp_pl = {32'h0000_0020, 32'h1234_5678, 4'b1111};
            else                           exp_pl = '0;
            check($sformatf("row%0d_payload", i),
                  {28'd0, s_mem_addr, s_mem_wdata, s_mem_wstrb, m0_mem_rdata, m1_mem_rdata},
                  {28'd0, exp_pl, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
            finish_cycle();
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset_n      = ($urandom_range(0, 99) != 0);
            m0_mem_valid = ($urandom_range(0, 3) != 0);
            m1_mem_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) m1_lock = ~m1_lock;
            s_mem_ready  = ($urandom_range(0, 2) == 0);
            m0_mem_addr  = $urandom; m0_mem_wdata = $urandom; m0_mem_wstrb = 4'($urandom);
            m1_mem_addr  = $urandom; m1_mem_wdata = $urandom; m1_mem_wstrb = 4'($urandom);
            s_mem_rdata  = $urandom;
            @(negedge clk);
            check($sformatf("rand%0d", c), dut_out(), model_out());
            finish_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
